register_bank: RTL and testbench

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank_pkg.sv | 19 +
 rtl/rb_read_port.sv | 44 ++++
 rtl/register_bank.sv | 114 +++++++++++
 tb/tb_register_bank.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/register_bank_pkg.sv
// Shared definitions for the register bank: default geometry, the address
// type for the default geometry, and the writable-address predicate used
// by both the write path and the read ports.
package register_bank_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_REGS   = 16;

    typedef logic [$clog2(DEFAULT_NUM_REGS)-1:0] addr_t;

    // An index names a real register if it is below num_regs, and is not
    // the hardwired-zero R0 when zero_r0 is set.
    function automatic logic addr_ok(input int unsigned addr,
                                     input int unsigned num_regs,
                                     input bit          zero_r0);
        return (addr < num_regs) && !(zero_r0 && (addr == 0));
    endfunction

endpackage

// File: rtl/rb_read_port.sv
// One combinational read port of the register bank.
//   addr      : register index to read
//   regs      : stored register contents
//   busy_bits : per-register busy flags
//   wr_valid  : a qualified (writable) write is presented this cycle
//   wr_addr   : write index
//   wr_data   : write data, forwarded when BYPASS and the indices match
//   data      : read data (0 for R0 with ZERO_R0 or out-of-range index)
//   busy      : addressed register awaits a write, unless the write is
//               being forwarded this very cycle
module rb_read_port
    import register_bank_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter bit ZERO_R0    = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
    input  logic [NUM_REGS-1:0]   busy_bits,
    input  logic                  wr_valid,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  busy
);

    logic in_range;
    logic hit;

    always_comb begin
        in_range = addr_ok(32'(addr), NUM_REGS, ZERO_R0);
        hit      = BYPASS && wr_valid && (wr_addr == addr);
        data     = '0;
        busy     = 1'b0;
        if (in_range) begin
            data = hit ? wr_data : regs[addr];
            busy = busy_bits[addr] && !hit;
        end
    end

endmodule

// File: rtl/register_bank.sv
// Two-read, one-write register bank with per-register busy (reservation)
// tracking and a registered count of busy registers.
//   clock      : rising-edge clock
//   clear_n    : asynchronous active-low reset
//   sync_clear : synchronous clear of all state, overrides write/reserve
//   wr_en/wr_addr/wr_data : write port, also clears the target's busy bit
//   rsv_en/rsv_addr       : reserve port, sets the target's busy bit
//   rd_addr_a/b -> rd_data_a/b, busy_a/b : combinational read ports
//   busy_count : number of busy registers
module register_bank
    import register_bank_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REGS   = DEFAULT_NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter bit ZERO_R0    = 1'b1,
    parameter bit BYPASS     = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT = '0
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  sync_clear,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rsv_en,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic [ADDR_WIDTH:0]   busy_count
);

    typedef logic [ADDR_WIDTH:0] count_t;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    count_t                count_next;
    logic                  wr_ok;
    logic                  rsv_ok;
    logic                  same_addr;

    always_comb begin
        wr_ok      = wr_en  && addr_ok(32'(wr_addr),  NUM_REGS, ZERO_R0);
        rsv_ok     = rsv_en && addr_ok(32'(rsv_addr), NUM_REGS, ZERO_R0);
        same_addr  = wr_ok && rsv_ok && (wr_addr == rsv_addr);
        busy_next  = busy;
        count_next = busy_count;
        // Reserve is applied after the write so it wins on the same index.
        if (wr_ok)  busy_next[wr_addr]  = 1'b0;
        if (rsv_ok) busy_next[rsv_addr] = 1'b1;
        // Incremental count: a reserve of an idle register adds one; a
        // write to a busy register removes one unless it is re-reserved.
        if (rsv_ok && !busy[rsv_addr])
            count_next = count_next + count_t'(1);
        if (wr_ok && busy[wr_addr] && !same_addr)
            count_next = count_next - count_t'(1);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= INIT;
            busy       <= '0;
            busy_count <= '0;
        end else if (sync_clear) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= INIT;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_ok) regs[wr_addr] <= wr_data;
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

    rb_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_R0    (ZERO_R0),
        .BYPASS     (BYPASS)
    ) u_port_a (
        .addr      (rd_addr_a),
        .regs      (regs),
        .busy_bits (busy),
        .wr_valid  (wr_ok),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .data      (rd_data_a),
        .busy      (busy_a)
    );

    rb_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_R0    (ZERO_R0),
        .BYPASS     (BYPASS)
    ) u_port_b (
        .addr      (rd_addr_b),
        .regs      (regs),
        .busy_bits (busy),
        .wr_valid  (wr_ok),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .data      (rd_data_b),
        .busy      (busy_b)
    );

endmodule

// File: tb/tb_register_bank.sv
`timescale 1ns/1ps
module tb_register_bank;
    import register_bank_pkg::*;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        sync_clear;
    logic        wr_en;
    addr_t       wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    addr_t       rsv_addr;
    addr_t       rd_addr_a;
    addr_t       rd_addr_b;

    logic [31:0] rd_data_a, rd_data_b;
    logic        busy_a, busy_b;
    logic [4:0]  busy_count;

    logic [31:0] nz_data_a, nz_data_b;
    logic        nz_busy_a, nz_busy_b;
    logic [4:0]  nz_count;

    logic [31:0] nb_data_a, nb_data_b;
    logic        nb_busy_a, nb_busy_b;
    logic [4:0]  nb_count;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    register_bank dut (
        .clock(clock), .clear_n(clear_n), .sync_clear(sync_clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .busy_a(busy_a), .busy_b(busy_b), .busy_count(busy_count)
    );

    register_bank #(.ZERO_R0(1'b0)) dut_nz (
        .clock(clock), .clear_n(clear_n), .sync_clear(sync_clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(nz_data_a), .rd_data_b(nz_data_b),
        .busy_a(nz_busy_a), .busy_b(nz_busy_b), .busy_count(nz_count)
    );

    register_bank #(.BYPASS(1'b0)) dut_nb (
        .clock(clock), .clear_n(clear_n), .sync_clear(sync_clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(nb_data_a), .rd_data_b(nb_data_b),
        .busy_a(nb_busy_a), .busy_b(nb_busy_b), .busy_count(nb_count)
    );

    typedef struct {
        logic        wr_en;
        logic [3:0]  wr_addr;
        logic [31:0] wr_data;
        logic        rsv_en;
        logic [3:0]  rsv_addr;
        logic [3:0]  rd_a;
        logic [3:0]  rd_b;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_busy_a;
        logic        exp_busy_b;
        logic [4:0]  exp_count;
        logic [31:0] nz_a;
        logic [31:0] nb_a;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        sync_clear = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rsv_en     = 1'b0;
        rsv_addr   = '0;
    endtask

    task automatic do_write(input addr_t a, input logic [31:0] d);
        @(negedge clock);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clock); #1;
        idle();
    endtask

    task automatic do_reserve(input addr_t a);
        @(negedge clock);
        rsv_en = 1'b1; rsv_addr = a;
        @(posedge clock); #1;
        idle();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'd5,  32'hDEADBEEF, 1'b0, 4'd0, 4'd5,  4'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 4'd5,  4'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 4'd0,  32'h12345678, 1'b0, 4'd0, 4'd0,  4'd0, 32'h0,        32'h0,        1'b0, 1'b0, 5'd0, 32'h12345678, 32'h0};
        vecs[3]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 4'd0,  4'd0, 32'h0,        32'h0,        1'b0, 1'b0, 5'd0, 32'h12345678, 32'h0};
        vecs[4]  = '{1'b1, 4'd3,  32'hA5A5A5A5, 1'b0, 4'd0, 4'd3,  4'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'hA5A5A5A5, 32'h0};
        vecs[5]  = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd7, 4'd7,  4'd3, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0};
        vecs[6]  = '{1'b0, 4'd0,  32'h0,        1'b1, 4'd9, 4'd7,  4'd9, 32'h0,        32'h0,        1'b1, 1'b0, 5'd1, 32'h0,        32'h0};
        vecs[7]  = '{1'b1, 4'd7,  32'h77,       1'b0, 4'd0, 4'd7,  4'd9, 32'h77,       32'h0,        1'b0, 1'b1, 5'd2, 32'h77,       32'h0};
        vecs[8]  = '{1'b1, 4'd9,  32'h99,       1'b1, 4'd9, 4'd7,  4'd9, 32'h77,       32'h99,       1'b0, 1'b0, 5'd1, 32'h77,       32'h77};
        vecs[9]  = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 4'd9,  4'd7, 32'h99,       32'h77,       1'b1, 1'b0, 5'd1, 32'h99,       32'h99};
        vecs[10] = '{1'b1, 4'd15, 32'hF,        1'b1, 4'd0, 4'd15, 4'd0, 32'hF,        32'h0,        1'b0, 1'b0, 5'd1, 32'hF,        32'h0};
        vecs[11] = '{1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 4'd15, 4'd0, 32'hF,        32'h0,        1'b0, 1'b0, 5'd1, 32'hF,        32'hF};

        // Power-up reset, checked before any clock edge.
        clear_n = 1'b0;
        idle();
        rd_addr_a = 4'd5;
        rd_addr_b = 4'd0;
        #2;
        check("reset_count", 32'(busy_count), 32'd0);
        check("reset_rd_a",  rd_data_a, 32'h0);
        check("reset_busy_a", 32'(busy_a), 32'd0);
        @(negedge clock);
        clear_n = 1'b1;

        // Directed table: inputs applied at the falling edge, outputs
        // compared just after, state advances at the following rising edge.
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            wr_en     = vecs[i].wr_en;
            wr_addr   = vecs[i].wr_addr;
            wr_data   = vecs[i].wr_data;
            rsv_en    = vecs[i].rsv_en;
            rsv_addr  = vecs[i].rsv_addr;
            rd_addr_a = vecs[i].rd_a;
            rd_addr_b = vecs[i].rd_b;
            #1;
            check($sformatf("v%0d_rd_a", i),   rd_data_a,          vecs[i].exp_a);
            check($sformatf("v%0d_rd_b", i),   rd_data_b,          vecs[i].exp_b);
            check($sformatf("v%0d_busy_a", i), 32'(busy_a),        32'(vecs[i].exp_busy_a));
            check($sformatf("v%0d_busy_b", i), 32'(busy_b),        32'(vecs[i].exp_busy_b));
            check($sformatf("v%0d_count", i),  32'(busy_count),    32'(vecs[i].exp_count));
            check($sformatf("v%0d_nz_rd_a", i), nz_data_a,         vecs[i].nz_a);
            check($sformatf("v%0d_nb_rd_a", i), nb_data_a,         vecs[i].nb_a);
            check($sformatf("v%0d_nb_count", i), 32'(nb_count),    32'(vecs[i].exp_count));
        end
        @(posedge clock); #1;
        idle();

        // Fill R1..R15 (clears R9's reservation), then reserve four.
        for (int i = 1; i < 16; i++) do_write(addr_t'(i), 32'h1000_0000 + i);
        do_reserve(4'd2);
        do_reserve(4'd4);
        do_reserve(4'd6);
        do_reserve(4'd8);
        rd_addr_a = 4'd8;
        rd_addr_b = 4'd13;
        #1;
        check("fill_count", 32'(busy_count), 32'd4);
        check("fill_rd_a",  rd_data_a, 32'h1000_0008);
        check("fill_rd_b",  rd_data_b, 32'h1000_000D);
        check("fill_busy_a", 32'(busy_a), 32'd1);

        // Asynchronous reset mid-cycle: state clears before the next edge.
        clear_n = 1'b0;
        #1;
        check("async_count", 32'(busy_count), 32'd0);
        check("async_rd_a",  rd_data_a, 32'h0);
        check("async_rd_b",  rd_data_b, 32'h0);
        check("async_busy_a", 32'(busy_a), 32'd0);
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = addr_t'(i);
            #1;
            check($sformatf("async_sweep_r%0d", i), rd_data_a, 32'h0);
        end

        // Write and reserve presented in the release cycle take effect.
        @(negedge clock);
        clear_n  = 1'b1;
        wr_en    = 1'b1; wr_addr  = 4'd6; wr_data = 32'h66;
        rsv_en   = 1'b1; rsv_addr = 4'd10;
        @(posedge clock); #1;
        idle();
        rd_addr_a = 4'd6;
        rd_addr_b = 4'd10;
        #1;
        check("release_rd_a",   rd_data_a, 32'h66);
        check("release_busy_b", 32'(busy_b), 32'd1);
        check("release_count",  32'(busy_count), 32'd1);

        // Synchronous clear overrides a simultaneous write and reserve.
        do_write(4'd4, 32'h44);
        do_reserve(4'd11);
        #1;
        check("pre_sync_count", 32'(busy_count), 32'd2);
        @(negedge clock);
        sync_clear = 1'b1;
        wr_en  = 1'b1; wr_addr  = 4'd4; wr_data = 32'hFFFFFFFF;
        rsv_en = 1'b1; rsv_addr = 4'd4;
        @(posedge clock); #1;
        idle();
        rd_addr_a = 4'd4;
        rd_addr_b = 4'd6;
        #1;
        check("sync_rd_a",   rd_data_a, 32'h0);
        check("sync_busy_a", 32'(busy_a), 32'd0);
        check("sync_rd_b",   rd_data_b, 32'h0);
        check("sync_count",  32'(busy_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
